// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT controller and sample buffer driving butterfly_raw.
// Define FFT_STAGE_SCALE_EN to halve every write-back (total 1/N scaling).
module fft_stage_sequencer #(
  parameter int LOG2N  = 3,
  parameter int BF_LAT = 3
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [23:0]  in_real,
  input  logic signed [23:0]  in_imag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [23:0]  out_real,
  output logic signed [23:0]  out_imag,
  output logic                out_last,
  output logic                busy,
  output logic [LOG2N-2:0]    tw_addr,
  input  logic signed [15:0]  tw_real,
  input  logic signed [15:0]  tw_imag,
  output logic                bf_en,
  output logic signed [23:0]  bf_xp_real,
  output logic signed [23:0]  bf_xp_imag,
  output logic signed [23:0]  bf_xq_real,
  output logic signed [23:0]  bf_xq_imag,
  output logic signed [15:0]  bf_factor_real,
  output logic signed [15:0]  bf_factor_imag,
  input  logic                bf_valid,
  input  logic signed [23:0]  bf_yp_real,
  input  logic signed [23:0]  bf_yp_imag,
  input  logic signed [23:0]  bf_yq_real,
  input  logic signed [23:0]  bf_yq_imag
);

  localparam int N   = 1 << LOG2N;
  localparam int AW  = LOG2N;
  localparam int BW  = LOG2N - 1;
  localparam int SW  = $clog2(LOG2N);
  localparam int INF = (BF_LAT + 1 > 4) ? BF_LAT + 1 : 4;
  localparam int PW  = $clog2(INF);
  localparam int FD  = 1 << PW;

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_UNLOAD = 2'd3;

  localparam logic [AW-1:0] LAST_K = AW'(N - 1);
  localparam logic [BW-1:0] LAST_B = '1;
  localparam logic [SW-1:0] LAST_S = SW'(LOG2N - 1);
  localparam logic [SW-1:0] BW_S   = SW'(BW);

  logic [1:0]    state;
  logic [AW-1:0] cnt;
  logic [BW-1:0] b;
  logic [BW-1:0] wb_cnt;
  logic [SW-1:0] stage;

  logic signed [23:0] mem_re [N];
  logic signed [23:0] mem_im [N];

  logic [AW-1:0] fifo_p [FD];
  logic [AW-1:0] fifo_q [FD];
  logic [PW-1:0] wp, rp;
  logic [PW:0]   fcnt;

  logic [AW-1:0] b_ext, span, pos;
  logic [AW-1:0] p_addr, q_addr, tw_full, ld_addr;
  logic [SW-1:0] tw_sh;
  logic          run, push, wb;
  logic [AW-1:0] wb_p, wb_q;

  logic signed [23:0] wr_pr, wr_pi, wr_qr, wr_qi;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  // Butterfly pair and twiddle index for issue slot b of the current stage
  always_comb begin
    b_ext   = {1'b0, b};
    span    = AW'(1) << stage;
    pos     = b_ext & (span - AW'(1));
    p_addr  = (((b_ext >> stage) << stage) << 1) | pos;
    q_addr  = p_addr | span;
    tw_sh   = BW_S - stage;
    tw_full = pos << tw_sh;
    ld_addr = bitrev(cnt);
  end

  assign run  = (state == S_ISSUE) || (state == S_DRAIN);
  assign push = (state == S_ISSUE);
  assign wb   = bf_valid && run && (fcnt != '0);
  assign wb_p = fifo_p[rp];
  assign wb_q = fifo_q[rp];

`ifdef FFT_STAGE_SCALE_EN
  assign wr_pr = bf_yp_real >>> 1;
  assign wr_pi = bf_yp_imag >>> 1;
  assign wr_qr = bf_yq_real >>> 1;
  assign wr_qi = bf_yq_imag >>> 1;
`else
  assign wr_pr = bf_yp_real;
  assign wr_pi = bf_yp_imag;
  assign wr_qr = bf_yq_real;
  assign wr_qi = bf_yq_imag;
`endif

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      mem_re[ld_addr] <= in_real;
      mem_im[ld_addr] <= in_imag;
    end
    if (wb) begin
      mem_re[wb_p] <= wr_pr;
      mem_im[wb_p] <= wr_pi;
      mem_re[wb_q] <= wr_qr;
      mem_im[wb_q] <= wr_qi;
    end
    if (push) begin
      fifo_p[wp] <= p_addr;
      fifo_q[wp] <= q_addr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_LOAD;
      cnt        <= '0;
      b          <= '0;
      wb_cnt     <= '0;
      stage      <= '0;
      wp         <= '0;
      rp         <= '0;
      fcnt       <= '0;
      bf_en      <= 1'b0;
      bf_xp_real <= '0;
      bf_xp_imag <= '0;
      bf_xq_real <= '0;
      bf_xq_imag <= '0;
      tw_addr    <= '0;
    end else begin
      bf_en <= 1'b0;
      if (push) wp <= wp + PW'(1);
      if (wb)   rp <= rp + PW'(1);
      case ({push, wb})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
      unique case (state)
        S_LOAD: begin
          if (in_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_K) begin
              state  <= S_ISSUE;
              stage  <= '0;
              b      <= '0;
              wb_cnt <= '0;
            end
          end
        end
        S_ISSUE: begin
          bf_en      <= 1'b1;
          bf_xp_real <= mem_re[p_addr];
          bf_xp_imag <= mem_im[p_addr];
          bf_xq_real <= mem_re[q_addr];
          bf_xq_imag <= mem_im[q_addr];
          tw_addr    <= tw_full[BW-1:0];
          b          <= b + 1'b1;
          if (b == LAST_B) state <= S_DRAIN;
        end
        S_DRAIN: ;
        S_UNLOAD: begin
          if (out_ready) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_K) state <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
      // Stage barrier: next stage issues only after its last write-back lands
      if (wb) begin
        wb_cnt <= wb_cnt + 1'b1;
        if (wb_cnt == LAST_B) begin
          if (stage == LAST_S) begin
            state <= S_UNLOAD;
          end else begin
            stage <= stage + 1'b1;
            state <= S_ISSUE;
          end
        end
      end
    end
  end

  assign in_ready       = (state == S_LOAD);
  assign out_valid      = (state == S_UNLOAD);
  assign busy           = run;
  assign out_real       = out_valid ? mem_re[cnt] : '0;
  assign out_imag       = out_valid ? mem_im[cnt] : '0;
  assign out_last       = out_valid && (cnt == LAST_K);
  assign bf_factor_real = bf_en ? tw_real : '0;
  assign bf_factor_imag = bf_en ? tw_imag : '0;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer, N = 8, with a Q13 butterfly model.
// Honours FFT_STAGE_SCALE_EN for the expected spectrum magnitudes.
module tb_fft_stage_sequencer;

  localparam int LAT = 3;
`ifdef FFT_STAGE_SCALE_EN
  localparam int IMP = 1024;
  localparam int DCV = 1000;
`else
  localparam int IMP = 8192;
  localparam int DCV = 8000;
`endif

  typedef struct packed {
    logic [7:0][23:0] x;
    logic [7:0][23:0] e;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [23:0] in_real = '0;
  logic signed [23:0] in_imag = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [23:0] out_real, out_imag;
  logic out_last, busy;
  logic [1:0] tw_addr;
  logic signed [15:0] tw_real, tw_imag;
  logic bf_en, bf_valid;
  logic signed [23:0] bf_xp_real, bf_xp_imag, bf_xq_real, bf_xq_imag;
  logic signed [15:0] bf_factor_real, bf_factor_imag;
  logic signed [23:0] bf_yp_real, bf_yp_imag, bf_yq_real, bf_yq_imag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_stage_sequencer #(.LOG2N(3), .BF_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag),
    .out_last(out_last), .busy(busy),
    .tw_addr(tw_addr), .tw_real(tw_real), .tw_imag(tw_imag),
    .bf_en(bf_en),
    .bf_xp_real(bf_xp_real), .bf_xp_imag(bf_xp_imag),
    .bf_xq_real(bf_xq_real), .bf_xq_imag(bf_xq_imag),
    .bf_factor_real(bf_factor_real), .bf_factor_imag(bf_factor_imag),
    .bf_valid(bf_valid),
    .bf_yp_real(bf_yp_real), .bf_yp_imag(bf_yp_imag),
    .bf_yq_real(bf_yq_real), .bf_yq_imag(bf_yq_imag)
  );

  // Twiddle ROM, W^k = exp(-j2pik/8) in Q13
  always_comb begin
    case (tw_addr)
      2'd0:    begin tw_real = 16'sd8192;  tw_imag = 16'sd0;     end
      2'd1:    begin tw_real = 16'sd5793;  tw_imag = -16'sd5793; end
      2'd2:    begin tw_real = 16'sd0;     tw_imag = -16'sd8192; end
      default: begin tw_real = -16'sd5793; tw_imag = -16'sd5793; end
    endcase
  end

  // Butterfly model: yp = xp + W*xq, yq = xp - W*xq, LAT cycles deep
  logic signed [47:0] m_re, m_im;
  assign m_re = (48'(bf_factor_real) * 48'(bf_xq_real)
               - 48'(bf_factor_imag) * 48'(bf_xq_imag)) >>> 13;
  assign m_im = (48'(bf_factor_real) * 48'(bf_xq_imag)
               + 48'(bf_factor_imag) * 48'(bf_xq_real)) >>> 13;

  logic [LAT-1:0] pv = '0;
  logic [LAT-1:0][23:0] ppr, ppi, pqr, pqi;

  always @(posedge clk) begin
    pv  <= {pv[LAT-2:0], bf_en};
    ppr <= {ppr[LAT-2:0], 24'(bf_xp_real + m_re[23:0])};
    ppi <= {ppi[LAT-2:0], 24'(bf_xp_imag + m_im[23:0])};
    pqr <= {pqr[LAT-2:0], 24'(bf_xp_real - m_re[23:0])};
    pqi <= {pqi[LAT-2:0], 24'(bf_xp_imag - m_im[23:0])};
  end

  assign bf_valid   = pv[LAT-1];
  assign bf_yp_real = ppr[LAT-1];
  assign bf_yp_imag = ppi[LAT-1];
  assign bf_yq_real = pqr[LAT-1];
  assign bf_yq_imag = pqi[LAT-1];

  int cyc = 0;
  int en_cyc[$];
  int tw_q[$];
  int val_cyc[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bf_en) begin
      en_cyc.push_back(cyc);
      tw_q.push_back(int'(tw_addr));
    end
    if (bf_valid) val_cyc.push_back(cyc);
  end

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input vec_t v, input string tag);
    en_cyc.delete();
    tw_q.delete();
    val_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_real  = v.x[k];
      in_imag  = '0;
      tick();
    end
    in_valid = 1'b0;
    chk({tag, " in_ready after load"}, 32'(in_ready), 0);
    chk({tag, " busy after load"}, 32'(busy), 1);
  endtask

  task automatic unload(input vec_t v, input bit stall, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    chk({tag, " out_valid reached"}, 32'(out_valid), 1);
    if (!out_valid) return;
    for (int i = 0; i < 8; i++) begin
      if (stall && i == 3) begin
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          tick();
          chk($sformatf("%s hold%0d re", tag, j), out_real, $signed(v.e[3]));
          chk($sformatf("%s hold%0d last", tag, j), 32'(out_last), 0);
        end
        out_ready = 1'b1;
      end
      chk($sformatf("%s bin%0d re", tag, i), out_real, $signed(v.e[i]));
      chk($sformatf("%s bin%0d im", tag, i), out_imag, 0);
      chk($sformatf("%s bin%0d last", tag, i), 32'(out_last), (i == 7) ? 1 : 0);
      tick();
    end
    chk({tag, " out_valid after unload"}, 32'(out_valid), 0);
    chk({tag, " in_ready after unload"}, 32'(in_ready), 1);
  endtask

  task automatic check_issue(input string tag);
    int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    chk({tag, " bf_en count"}, en_cyc.size(), 12);
    chk({tag, " bf_valid count"}, val_cyc.size(), 12);
    if (en_cyc.size() >= 12 && val_cyc.size() >= 12) begin
      for (int i = 0; i < 12; i++)
        chk($sformatf("%s tw_addr[%0d]", tag, i), tw_q[i], exp_tw[i]);
      for (int r = 0; r < 3; r++)
        chk($sformatf("%s stage%0d burst", tag, r),
            en_cyc[4*r+3] - en_cyc[4*r], 3);
      for (int r = 1; r < 3; r++)
        chk($sformatf("%s stage%0d barrier", tag, r),
            32'(en_cyc[4*r] > val_cyc[4*r-1]), 1);
    end
  endtask

  vec_t  tv[3];
  string nm[3] = '{"impulse", "dc", "alt"};

  initial begin
    for (int k = 0; k < 8; k++) begin
      tv[0].x[k] = (k == 0) ? 24'd8192 : 24'd0;
      tv[0].e[k] = 24'(IMP);
      tv[1].x[k] = 24'd1000;
      tv[1].e[k] = (k == 0) ? 24'(DCV) : 24'd0;
      tv[2].x[k] = (k % 2 == 0) ? 24'd1000 : 24'(-1000);
      tv[2].e[k] = (k == 4) ? 24'(DCV) : 24'd0;
    end

    rstn = 1'b0;
    repeat (3) tick();
    chk("reset in_ready", 32'(in_ready), 1);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset bf_en", 32'(bf_en), 0);
    chk("reset busy", 32'(busy), 0);
    rstn = 1'b1;
    tick();

    for (int v = 0; v < 3; v++) begin
      load(tv[v], nm[v]);
      unload(tv[v], 1'b0, nm[v]);
      check_issue(nm[v]);
    end

    load(tv[1], "dc_stall");
    unload(tv[1], 1'b1, "dc_stall");

    // Abandon a transform during stage 1 issue
    load(tv[2], "midrst");
    for (int n = 0; n < 100 && en_cyc.size() < 5; n++) tick();
    chk("midrst reached stage1", 32'(en_cyc.size() >= 5), 1);
    rstn = 1'b0;
    #1;
    chk("midrst in_ready", 32'(in_ready), 1);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst bf_en", 32'(bf_en), 0);
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    load(tv[0], "post_rst");
    unload(tv[0], 1'b0, "post_rst");
    check_issue("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Controller and in-place sample buffer for an N-point radix-2 DIT FFT.
- Drives the team's butterfly_raw datapath as its initiator: issues p/q operand pairs plus twiddle, collects pipelined results, writes them back in place.
- Loads time-domain samples serially, runs log2(N) stages, then streams the frequency-domain result out in natural order.
- Sits between the sample source and spectrum consumer; twiddles come from an external combinational ROM addressed by this block.

Parameters:
- LOG2N, 3, log2 of FFT size N (N = 2^LOG2N, legal 2..10).
- BF_LAT, 3, butterfly latency in cycles from bf_en to bf_valid (informational; write-back is keyed on bf_valid).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts a sample
- in_real / in_imag  in  24 each  signed input sample
- out_valid  out  1  output sample valid
- out_ready  in  1  consumer accepts a sample
- out_real / out_imag  out  24 each  signed spectrum bin
- out_last  out  1  marks bin N-1
- busy  out  1  high in RUN_ISSUE/RUN_DRAIN
- tw_addr  out  LOG2N-1  twiddle ROM index k, W = exp(-j2πk/N), Q13 (8192 = 1.0)
- tw_real / tw_imag  in  16 each  ROM data (combinational on tw_addr)
- bf_en  out  1  butterfly issue strobe
- bf_xp_real / bf_xp_imag / bf_xq_real / bf_xq_imag  out  24 each  butterfly operands
- bf_factor_real / bf_factor_imag  out  16 each  twiddle passed through from tw_real/tw_imag
- bf_valid  in  1  butterfly result valid
- bf_yp_real / bf_yp_imag / bf_yq_real / bf_yq_imag  in  24 each  butterfly results

Behaviour:
- Reset: single clock clk; asynchronous active-low reset rstn.
  - In reset: state LOAD, all counters 0.
  - Outputs 0 except in_ready = 1.
  - Buffer contents are not reset.
  - Reset mid-operation abandons the transform; results still in the butterfly pipeline are ignored.
- LOAD: in_ready = 1.
  - Each in_valid & in_ready writes sample k to buffer address bitrev(k), k = 0..N-1.
  - After sample N-1: in_ready = 0 next cycle, enter RUN_ISSUE with stage s = 0.
- RUN_ISSUE: one butterfly per cycle, b = 0..N/2-1, bf_en = 1 on exactly N/2 consecutive cycles.
  - span = 2^s, pos = b & (span-1), p = (b >> s)*2*span + pos, q = p + span.
  - tw_addr = pos << (LOG2N-1-s).
  - Operands are read from buffer[p] and buffer[q] and presented registered, aligned with bf_en and bf_factor_*.
  - The (p, q) pair is pushed into a 4-deep address FIFO on each bf_en.
- RUN_DRAIN: each bf_valid pops the FIFO and writes yp to buffer[p] and yq to buffer[q] in the same cycle.
  - Stage barrier: stage s+1 issue begins no earlier than the cycle after the N/2-th write-back of stage s.
  - After the last write-back of stage LOG2N-1, enter UNLOAD.
- UNLOAD: present buffer[i] for i = 0..N-1 with out_valid = 1.
  - Data and out_last hold stable while out_ready = 0.
  - Index advances on out_valid & out_ready.
  - After bin N-1 is accepted: out_valid = 0 next cycle, enter LOAD with in_ready = 1.
- bf_valid outside RUN states, or with an empty FIFO, is ignored.
- Arithmetic: no width growth inside this block; samples stored as 24-bit signed. Scaling by Q13 twiddle is handled by the butterfly.
- Throughput: N cycles load + LOG2N*(N/2 + BF_LAT + 1) run + N cycles unload, with no stalls.

Optional Feature:
- Macro: FFT_STAGE_SCALE_EN.
- Defined: every write-back is arithmetically shifted right by 1 (floor) before storage, giving a total 1/N scaling that prevents overflow.
- Undefined: results are written back unmodified.

Test Plan:
- Reset with rstn = 0 for 3 cycles:
  - in_ready = 1, out_valid = 0, bf_en = 0, busy = 0.
- Impulse, N = 8: x[0] = 8192, others 0 (imag 0):
  - 8 outputs real = 8192, imag = 0.
  - out_last only on the 8th output.
  - With FFT_STAGE_SCALE_EN: real = 1024.
- DC: all x = 1000:
  - bin 0 = 8000 + j0, bins 1..7 = 0.
- Alternating +1000/−1000:
  - bin 4 = 8000, all other bins 0.
- Issue pattern, N = 8:
  - bf_en high 4 consecutive cycles per stage, 3 stages.
  - tw_addr sequence: stage 0 = 0,0,0,0; stage 1 = 0,2,0,2; stage 2 = 0,1,2,3.
  - Each stage's first bf_en comes at least one cycle after the prior stage's 4th bf_valid.
- Backpressure and reset:
  - Drop out_ready for 5 cycles at bin 3: bin 3 held stable, no bin lost or duplicated.
  - Assert rstn = 0 during RUN_ISSUE of stage 1: returns to LOAD with in_ready = 1.
  - A following impulse transform is still correct.
